// File: rtl/led_strip_pkg.sv
// Shared definitions for the LED strip driver.
// Holds the frame state encoding, default WS281x timing at 50 MHz and the
// bit offsets of each colour field inside a 32-bit {G,R,B,W} pixel word.
package led_strip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int unsigned DEF_CYCLES_0_HIGH = 21;
  localparam int unsigned DEF_CYCLES_1_HIGH = 42;
  localparam int unsigned DEF_CYCLES_BIT    = 63;
  localparam int unsigned DEF_CYCLES_RESET  = 2600;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned PIX_W  = 32;

  // Colour fields within a pixel word, most significant first on the wire.
  localparam int unsigned OFS_G = 24;
  localparam int unsigned OFS_R = 16;
  localparam int unsigned OFS_B = 8;
  localparam int unsigned OFS_W = 0;

  // Wire order is MSB-first starting at the top of the G field.
  localparam int unsigned FIRST_BIT = OFS_G + 7;

endpackage

// File: rtl/led_bit_timer.sv
// Shared bit-phase timer for all strands.
// Ports: clk_i/rst_i clock and sync reset; run_i enables counting (clears
// the phase when low); bit_end_c marks the last cycle of a bit;
// high_window_0_c / high_window_1_c are high while a 0 / 1 bit is high.
module led_bit_timer
  import led_strip_pkg::*;
#(
  parameter int unsigned CYCLES_0_HIGH = DEF_CYCLES_0_HIGH,
  parameter int unsigned CYCLES_1_HIGH = DEF_CYCLES_1_HIGH,
  parameter int unsigned CYCLES_BIT    = DEF_CYCLES_BIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic bit_end_c,
  output logic high_window_0_c,
  output logic high_window_1_c
);

  localparam int unsigned PH_W = (CYCLES_BIT > 1) ? $clog2(CYCLES_BIT) : 1;

  logic [PH_W-1:0] phase_q, phase_d;

  // Phase decode shared by every channel.
  always_comb begin
    bit_end_c       = run_i && (phase_q == PH_W'(CYCLES_BIT - 1));
    high_window_0_c = phase_q < PH_W'(CYCLES_0_HIGH);
    high_window_1_c = phase_q < PH_W'(CYCLES_1_HIGH);
    phase_d         = (!run_i || bit_end_c) ? '0 : phase_q + PH_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/led_strip_driver.sv
// Multi-strand WS281x-style serial LED driver.
// Ports: clk_i, rst_i (sync, active-high); start_i requests a frame;
// continuous_i chains frames back to back; busy_o spans LOAD..GAP;
// frame_done_o pulses in the last GAP cycle; address_o indexes the external
// pixel memory (1-cycle read latency); pixel_i carries {G,R,B,W} per
// channel; data_o is the registered serial bit per strand.
module led_strip_driver
  import led_strip_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned LED_COUNT     = 300,
  parameter int unsigned BITS_PER_LED  = 24,
  parameter int unsigned REVERSE       = 0,
  parameter int unsigned CYCLES_0_HIGH = DEF_CYCLES_0_HIGH,
  parameter int unsigned CYCLES_1_HIGH = DEF_CYCLES_1_HIGH,
  parameter int unsigned CYCLES_BIT    = DEF_CYCLES_BIT,
  parameter int unsigned CYCLES_RESET  = DEF_CYCLES_RESET
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      continuous_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic [8:0]                address_o,
  input  logic [CHANNELS*32-1:0]    pixel_i,
  output logic [CHANNELS-1:0]       data_o
);

  localparam int unsigned BIT_W = $clog2(BITS_PER_LED);
  localparam int unsigned GAP_W = (CYCLES_RESET > 1) ? $clog2(CYCLES_RESET) : 1;
  localparam logic [ADDR_W-1:0] LAST_LED  = ADDR_W'(LED_COUNT - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = (REVERSE != 0) ? LAST_LED : '0;

  state_e state_q, state_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [CHANNELS-1:0]           data_q, data_d;
  logic [CHANNELS-1:0][PIX_W-1:0] sr_q, sr_d;
  logic [CHANNELS-1:0][PIX_W-1:0] shadow_q, shadow_d;
  logic [BIT_W-1:0]              bit_q, bit_d;
  logic [ADDR_W-1:0]             led_q, led_d;
  logic [GAP_W-1:0]              gap_q, gap_d;

  logic bit_end, hw0, hw1;
  logic last_bit, last_led, gap_last;

  led_bit_timer #(
    .CYCLES_0_HIGH (CYCLES_0_HIGH),
    .CYCLES_1_HIGH (CYCLES_1_HIGH),
    .CYCLES_BIT    (CYCLES_BIT)
  ) u_timer (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .run_i           (state_q == ST_SHIFT),
    .bit_end_c       (bit_end),
    .high_window_0_c (hw0),
    .high_window_1_c (hw1)
  );

  assign last_bit = (bit_q == BIT_W'(BITS_PER_LED - 1));
  assign last_led = (led_q == LAST_LED);
  assign gap_last = (gap_q == GAP_W'(CYCLES_RESET - 1));

  // State register and datapath flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= FIRST_IDX;
      data_q   <= '0;
      sr_q     <= '0;
      shadow_q <= '0;
      bit_q    <= '0;
      led_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      led_q    <= led_d;
      gap_q    <= gap_d;
    end
  end

  // Next-state logic; start_i only matters in IDLE and the final GAP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (bit_end && last_bit && last_led) state_d = ST_GAP;
      ST_GAP:   if (gap_last) state_d = (continuous_i || start_i) ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    addr_d   = addr_q;
    data_d   = '0;
    sr_d     = sr_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    led_d    = led_q;
    gap_d    = gap_q;
    case (state_q)
      ST_LOAD: begin
        for (int unsigned c = 0; c < CHANNELS; c++) sr_d[c] = pixel_i[c*32 +: 32];
        bit_d = '0;
        led_d = '0;
      end
      ST_SHIFT: begin
        for (int unsigned c = 0; c < CHANNELS; c++)
          data_d[c] = sr_q[c][FIRST_BIT] ? hw1 : hw0;
        if (bit_end) begin
          if (last_bit) begin
            bit_d = '0;
            if (!last_led) begin
              sr_d  = shadow_q;
              led_d = led_q + ADDR_W'(1);
            end else begin
              // Rewind so a chained LOAD already presents the first index.
              addr_d = FIRST_IDX;
              gap_d  = '0;
            end
          end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) sr_d[c] = sr_q[c] << 1;
            bit_d = bit_q + BIT_W'(1);
            // Prefetch address early; the shadow grabs it when the last bit starts.
            if (bit_q == '0 && !last_led)
              addr_d = (REVERSE != 0) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            if (bit_q == BIT_W'(BITS_PER_LED - 2) && !last_led)
              for (int unsigned c = 0; c < CHANNELS; c++) shadow_d[c] = pixel_i[c*32 +: 32];
          end
        end
      end
      ST_GAP: gap_d = gap_last ? '0 : gap_q + GAP_W'(1);
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
    // Registered one cycle ahead so the pulse coincides with the last GAP cycle.
    done_d = (state_d == ST_GAP) && (gap_d == GAP_W'(CYCLES_RESET - 1));
  end

  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign address_o    = addr_q;
  assign data_o       = data_q;

endmodule

// File: tb/tb_led_strip_driver.sv
// Directed self-checking bench for led_strip_driver (2 channels, 3 LEDs).
// Three instances: base (GRB), REVERSE=1, and BITS_PER_LED=32.
module tb_led_strip_driver;

  localparam int HN = 9000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, cont_a, start_r, start_w;
  logic cont_r, cont_w;
  logic [63:0] pix_a, pix_r, pix_w;
  logic busy_a, busy_r, busy_w, done_a, done_r, done_w;
  logic [8:0] addr_a, addr_r, addr_w;
  logic [1:0] data_a, data_r, data_w;

  led_strip_driver #(.CHANNELS(2), .LED_COUNT(3), .BITS_PER_LED(24), .REVERSE(0)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .continuous_i(cont_a),
    .busy_o(busy_a), .frame_done_o(done_a), .address_o(addr_a),
    .pixel_i(pix_a), .data_o(data_a));

  led_strip_driver #(.CHANNELS(2), .LED_COUNT(3), .BITS_PER_LED(24), .REVERSE(1)) u_r (
    .clk_i(clk), .rst_i(rst), .start_i(start_r), .continuous_i(cont_r),
    .busy_o(busy_r), .frame_done_o(done_r), .address_o(addr_r),
    .pixel_i(pix_r), .data_o(data_r));

  led_strip_driver #(.CHANNELS(2), .LED_COUNT(3), .BITS_PER_LED(32), .REVERSE(0)) u_w (
    .clk_i(clk), .rst_i(rst), .start_i(start_w), .continuous_i(cont_w),
    .busy_o(busy_w), .frame_done_o(done_w), .address_o(addr_w),
    .pixel_i(pix_w), .data_o(data_w));

  // Pixel memory for the base instance, 1-cycle read latency.
  always @(posedge clk) begin
    case (addr_a)
      9'd0:    pix_a <= {32'hFF000000, 32'h80000100};
      9'd1:    pix_a <= {32'h00000000, 32'h80000100};
      9'd2:    pix_a <= {32'h0F0F0F00, 32'h80000100};
      default: pix_a <= '0;
    endcase
  end

  int sel;
  logic [1:0] cur_d;
  logic cur_b, cur_f;
  logic [8:0] cur_a;
  always_comb begin
    case (sel)
      1:       begin cur_d = data_r; cur_b = busy_r; cur_f = done_r; cur_a = addr_r; end
      2:       begin cur_d = data_w; cur_b = busy_w; cur_f = done_w; cur_a = addr_w; end
      default: begin cur_d = data_a; cur_b = busy_a; cur_f = done_a; cur_a = addr_a; end
    endcase
  end

  logic [1:0] h_d [0:HN-1];
  logic       h_b [0:HN-1];
  logic       h_f [0:HN-1];
  logic [8:0] h_a [0:HN-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      h_d[i] = cur_d; h_b[i] = cur_b; h_f[i] = cur_f; h_a[i] = cur_a;
      step();
    end
  endtask

  function automatic int hi_cnt(input int ch, input int from, input int len);
    int s = 0;
    for (int i = from; i < from + len; i++) if (h_d[i][ch] === 1'b1) s++;
    return s;
  endfunction

  function automatic int cnt_b(input int from, input int len);
    int s = 0;
    for (int i = from; i < from + len; i++) if (h_b[i] === 1'b1) s++;
    return s;
  endfunction

  function automatic int cnt_f(input int from, input int len);
    int s = 0;
    for (int i = from; i < from + len; i++) if (h_f[i] === 1'b1) s++;
    return s;
  endfunction

  initial begin
    int j, s, chg;
    rst = 1'b1; start_a = 1'b0; start_r = 1'b0; start_w = 1'b0;
    cont_a = 1'b0; cont_r = 1'b0; cont_w = 1'b0; sel = 0;
    pix_r = {32'h00000000, 32'h80000100};
    pix_w = {32'h00000000, 32'h000000FF};
    repeat (3) step();
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_data_a", int'(data_a), 0);
    check("rst_addr_a", int'(addr_a), 0);
    check("rst_addr_r", int'(addr_r), 2);
    check("rst_addr_w", int'(addr_w), 0);
    rst = 1'b0;
    repeat (20) step();
    check("no_poweron_gap", int'(busy_a) + int'(busy_r) + int'(busy_w), 0);

    // Single frame, pixel ch0 = 0x800001.
    sel = 0; start_a = 1'b1; step(); start_a = 1'b0;
    record(7200);
    check("a_busy_len", cnt_b(0, 7200), 7137);
    check("a_busy_first", int'(h_b[0]), 1);
    check("a_busy_fall", int'(h_b[7137]), 0);
    check("a_done_cnt", cnt_f(0, 7200), 1);
    check("a_done_pos", int'(h_f[7136]), 1);
    check("a_lag", int'(h_d[1][0]), 0);
    check("a_rise", int'(h_d[2][0]), 1);
    check("a_bit0_last_hi", int'(h_d[43][0]), 1);
    check("a_bit0_first_lo", int'(h_d[44][0]), 0);
    check("a_bit0_hi", hi_cnt(0, 2, 63), 42);
    s = 0;
    for (int b = 1; b <= 22; b++) if (hi_cnt(0, 2 + b*63, 63) == 21) s++;
    check("a_bits1_22_short", s, 22);
    check("a_bit23_hi", hi_cnt(0, 2 + 23*63, 63), 42);
    check("a_ch0_total", hi_cnt(0, 0, 7200), 1638);
    check("a_ch1_led0", hi_cnt(1, 2, 1512), 672);
    check("a_ch1_led1", hi_cnt(1, 2 + 1512, 1512), 504);
    check("a_ch1_led2", hi_cnt(1, 2 + 3024, 1512), 756);
    check("a_gap_low", hi_cnt(0, 4538, 2662) + hi_cnt(1, 4538, 2662), 0);
    check("a_addr_pre", int'(h_a[63]), 0);
    check("a_addr_adv", int'(h_a[64]), 1);
    check("a_addr_end", int'(h_a[7137]), 0);

    // REVERSE=1 address sequence.
    sel = 1; start_r = 1'b1; step(); start_r = 1'b0;
    record(7200);
    check("r_addr_load", int'(h_a[0]), 2);
    check("r_addr_63", int'(h_a[63]), 2);
    check("r_addr_64", int'(h_a[64]), 1);
    check("r_addr_1575", int'(h_a[1575]), 1);
    check("r_addr_1576", int'(h_a[1576]), 0);
    chg = 0;
    for (int i = 1; i < 4537; i++) if (h_a[i] !== h_a[i-1]) chg++;
    check("r_addr_changes", chg, 2);
    check("r_busy_len", cnt_b(0, 7200), 7137);

    // BITS_PER_LED=32, W=0xFF, GRB=0.
    sel = 2; start_w = 1'b1; step(); start_w = 1'b0;
    record(8700);
    check("w_busy_len", cnt_b(0, 8700), 8649);
    check("w_bit0", hi_cnt(0, 2, 63), 21);
    check("w_bit23", hi_cnt(0, 2 + 23*63, 63), 21);
    check("w_bit24", hi_cnt(0, 2 + 24*63, 63), 42);
    check("w_bit31", hi_cnt(0, 2 + 31*63, 63), 42);
    check("w_led1_bit0", hi_cnt(0, 2 + 2016, 63), 21);
    check("w_led1_bit24", hi_cnt(0, 2 + 2016 + 24*63, 63), 42);
    check("w_ch0_total", hi_cnt(0, 0, 8700), 2520);
    check("w_addr_2079", int'(h_a[2079]), 1);
    check("w_addr_2080", int'(h_a[2080]), 2);

    // Continuous mode: next LOAD immediately after frame_done_o.
    sel = 0; cont_a = 1'b1; start_a = 1'b1; step(); start_a = 1'b0;
    j = -1;
    for (int i = 0; i < 8000; i++) begin
      if (busy_a === 1'b1 && done_a === 1'b1) begin j = i; break; end
      step();
    end
    check("c_done_pos", j, 7136);
    step(); cont_a = 1'b0;
    check("c_no_idle", int'(busy_a), 1);
    record(7200);
    check("c_lag", int'(h_d[1][0]), 0);
    check("c_rise", int'(h_d[2][0]), 1);
    check("c_done2_pos", int'(h_f[7136]), 1);
    check("c_busy2_len", cnt_b(0, 7200), 7137);

    // start_i held high through a frame.
    start_a = 1'b1; step();
    record(7200);
    check("h_done_once", cnt_f(0, 7137), 1);
    check("h_done_pos", int'(h_f[7136]), 1);
    check("h_busy_all", cnt_b(0, 7200), 7200);
    check("h_next_lag", int'(h_d[7138][0]), 0);
    check("h_next_rise", int'(h_d[7139][0]), 1);
    start_a = 1'b0;
    j = -1;
    for (int i = 0; i < 8000; i++) begin
      if (busy_a === 1'b0) begin j = i; break; end
      step();
    end
    check("h_end_idle", int'(j >= 0), 1);

    // Reset mid-bit at cycle 100.
    sel = 0; start_a = 1'b1; step(); start_a = 1'b0;
    repeat (100) step();
    check("x_pre_high", int'(data_a[1]), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("x_data", int'(data_a), 0);
    check("x_busy", int'(busy_a), 0);
    record(300);
    check("x_stay_idle", cnt_b(0, 300), 0);
    check("x_stay_low", hi_cnt(0, 0, 300) + hi_cnt(1, 0, 300), 0);
    check("x_addr", int'(addr_a), 0);
    start_a = 1'b1; step(); start_a = 1'b0;
    check("x_restart_busy", int'(busy_a), 1);
    record(3);
    check("x_restart_rise", int'(h_d[2][0]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_strip_driver.md
LED_STRIP_DRIVER -- requirements
Module: led_strip_driver

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of parallel strands driven in lockstep (1..8).
REQ-002 SHALL have parameter LED_COUNT, default 300: LEDs per strand (1..512).
REQ-003 SHALL have parameter BITS_PER_LED, default 24: 24 (GRB) or 32 (GRBW); other values are illegal.
REQ-004 SHALL have parameter REVERSE, default 0: nonzero means address_o counts LED_COUNT-1 down to 0.
REQ-005 SHALL have parameters CYCLES_0_HIGH 21, CYCLES_1_HIGH 42, CYCLES_BIT 63, CYCLES_RESET 2600: clk_i cycles at 50 MHz.
REQ-006 SHALL have port clk_i, input, 1: the single clock.
REQ-007 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port start_i, input, 1: level-sampled request to send one frame.
REQ-009 SHALL have port continuous_i, input, 1: when high at frame end, the next frame starts with no start_i.
REQ-010 SHALL have port busy_o, output, 1: high from frame start through the end of the reset gap.
REQ-011 SHALL have port frame_done_o, output, 1: one-cycle pulse at the end of the reset gap.
REQ-012 SHALL have port address_o, output, 9: LED index for the external pixel memory, shared by all channels.
REQ-013 SHALL have port pixel_i, input, CHANNELS*32: per channel c, bits [32c+31:32c] = {G,R,B,W}; W is ignored when BITS_PER_LED=24.
REQ-014 SHALL have port data_o, output, CHANNELS: registered serial output, one bit per strand.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT and GAP.
REQ-016 IDLE -> LOAD SHALL occur when start_i=1; busy_o SHALL rise on the same edge.
REQ-017 LOAD SHALL last exactly one cycle, with address_o = first index (0, or LED_COUNT-1 if REVERSE); pixel_i SHALL be captured at the end of LOAD, so the memory has 1-cycle read latency.
REQ-018 In SHIFT, each bit SHALL last CYCLES_BIT cycles, high for CYCLES_1_HIGH cycles if the bit is 1 or CYCLES_0_HIGH cycles if 0, then low.
REQ-019 Bit order SHALL be MSB-first: G[7]..G[0], R, B, then W when BITS_PER_LED=32.
REQ-020 During the first bit of LED k, address_o SHALL advance to LED k+1; the next pixel SHALL be captured into a shadow register at the start of the last bit of LED k and transferred without any gap cycle.
REQ-021 data_o SHALL lag the internal phase by exactly one register stage.
REQ-022 After the last bit of the last LED, the block SHALL enter GAP, with data_o low for all channels for CYCLES_RESET cycles.
REQ-023 At the final GAP cycle, frame_done_o SHALL pulse; next state SHALL be LOAD if continuous_i=1 or start_i=1, otherwise IDLE with busy_o falling.
REQ-024 start_i SHALL be ignored while busy_o=1, except as sampled in REQ-023.
REQ-025 Address arithmetic SHALL be 9-bit with no wrap beyond LED_COUNT-1/0.
REQ-026 With LED_COUNT=1, address_o SHALL stay constant and no prefetch read beyond index 0 SHALL be issued.

Reset
REQ-027 While rst_i=1, the block SHALL set state=IDLE, data_o=0, busy_o=0, frame_done_o=0, address_o = first index, and clear the phase, bit and LED counters.
REQ-028 Reset mid-frame SHALL force data_o low on the next edge, with no partial bit completed.
REQ-029 After reset the block SHALL wait for start_i and SHALL NOT emit a power-on reset gap.

Structure
REQ-030 Package led_strip_pkg SHALL hold the state enum, the default timing constants, and the colour-order bit offsets.
REQ-031 Sub-module led_bit_timer SHALL hold the single shared phase counter and SHALL output bit_end and high_window_0/high_window_1; the per-channel logic SHALL be only a shift register plus a select.

Verification (CHANNELS=2, LED_COUNT=3, BITS_PER_LED=24 unless noted)
REQ-032 Bench SHALL cover: pixel ch0 = 0x800001, single start_i pulse -> ch0 first bit high for 42 cycles, low 21, then 22 bits of 21-high, last bit 42-high; busy_o high for 1+4536+2600 cycles; frame_done_o pulses exactly once.
REQ-033 Bench SHALL cover: REVERSE=1 -> address_o sequence 2,1,0, with each change 63 cycles after the start of a pixel's first bit.
REQ-034 Bench SHALL cover: BITS_PER_LED=32, W=0xFF, GRB=0 -> 24 short bits then 8 long bits per LED, with LED period 2016 cycles.
REQ-035 Bench SHALL cover: continuous_i=1 -> the second LOAD occurs the cycle after frame_done_o, with no idle cycle between frames.
REQ-036 Bench SHALL cover: rst_i asserted for 1 cycle mid-bit at cycle 100 -> data_o=0 and busy_o=0 on the next edge, and the block stays idle until start_i.
REQ-037 Bench SHALL cover: start_i held high during a frame -> no restart until GAP completes; the next frame begins immediately after frame_done_o.
